// File: rtl/cellram_ctrl.sv
// Asynchronous-mode CellularRAM controller: one request per SETUP/ACCESS/HOLD sequence.
// Every RAM-side strobe, the bus output-enable and the host-side status come straight from flops.
module cellram_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        cfg,
  input  logic [22:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  be,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [23:1] MemAdr,
  inout  wire  [15:0] MemDB,
  output logic        MemOE,
  output logic        MemWR,
  output logic        RamCS,
  output logic        RamAdv,
  output logic        RamLB,
  output logic        RamUB,
  output logic        RamCRE,
  output logic        RamClk,
  input  logic        RamWait
);

  localparam int unsigned AccEff  = (ACCESS_CYCLES == 0) ? 1 : ACCESS_CYCLES;
  localparam logic [3:0]  CntLoad = 4'(AccEff - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t      state, stateNxt;
  logic [3:0]  cnt, cntNxt;
  logic        wrQ, cfgQ;
  logic [1:0]  beQ;
  logic [15:0] wdataQ;
  logic        dbOe;

  logic        accept, selWr, selCfg;
  logic [1:0]  selBe;
  logic        csNxt, advNxt, oeNxt, wrNxt, lbNxt, ubNxt, creNxt, dbOeNxt, ackNxt, busyNxt;

  logic        unusedWait;
  assign unusedWait = RamWait;

  assign RamClk = 1'b0;
  assign MemDB  = dbOe ? wdataQ : {16{1'bz}};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next state plus the strobe values that belong to the state being entered
  always_comb begin
    accept   = (state == IDLE) && req;
    selWr    = accept ? (we | cfg) : wrQ;
    selCfg   = accept ? cfg : cfgQ;
    selBe    = accept ? be : beQ;
    stateNxt = state;
    cntNxt   = cnt;
    csNxt    = 1'b1;
    advNxt   = 1'b1;
    oeNxt    = 1'b1;
    wrNxt    = 1'b1;
    lbNxt    = 1'b1;
    ubNxt    = 1'b1;
    creNxt   = 1'b0;
    dbOeNxt  = 1'b0;
    ackNxt   = 1'b0;

    unique case (state)
      IDLE:    if (req) stateNxt = SETUP;
      SETUP:   begin
                 stateNxt = ACCESS;
                 cntNxt   = CntLoad;
               end
      ACCESS:  if (cnt == 4'd0) stateNxt = HOLD;
               else             cntNxt   = cnt - 4'd1;
      HOLD:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase

    unique case (stateNxt)
      SETUP, ACCESS: begin
        csNxt   = 1'b0;
        advNxt  = 1'b0;
        creNxt  = selCfg;
        // cfg masks both lanes; reads enable both; writes follow be
        {ubNxt, lbNxt} = selCfg ? 2'b11 : (selWr ? ~selBe : 2'b00);
        dbOeNxt = selWr & ~selCfg;
        if (stateNxt == ACCESS) begin
          oeNxt = selWr;
          wrNxt = ~selWr;
        end
      end
      HOLD: begin
        dbOeNxt = selWr & ~selCfg;
        ackNxt  = 1'b1;
      end
      default: ;
    endcase

    busyNxt = (stateNxt != IDLE);
  end

  // Registered strobes and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RamCS  <= 1'b1;
      RamAdv <= 1'b1;
      MemOE  <= 1'b1;
      MemWR  <= 1'b1;
      RamLB  <= 1'b1;
      RamUB  <= 1'b1;
      RamCRE <= 1'b0;
      dbOe   <= 1'b0;
      ack    <= 1'b0;
      busy   <= 1'b0;
      cnt    <= 4'd0;
    end else begin
      RamCS  <= csNxt;
      RamAdv <= advNxt;
      MemOE  <= oeNxt;
      MemWR  <= wrNxt;
      RamLB  <= lbNxt;
      RamUB  <= ubNxt;
      RamCRE <= creNxt;
      dbOe   <= dbOeNxt;
      ack    <= ackNxt;
      busy   <= busyNxt;
      cnt    <= cntNxt;
    end
  end

  // Request latch and read capture; MemAdr doubles as the latched address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemAdr <= 23'd0;
      wrQ    <= 1'b0;
      cfgQ   <= 1'b0;
      beQ    <= 2'b00;
      wdataQ <= 16'd0;
      rdata  <= 16'd0;
    end else begin
      if (accept) begin
        MemAdr <= addr;
        wrQ    <= we | cfg;
        cfgQ   <= cfg;
        beQ    <= be;
        wdataQ <= wdata;
      end
      if ((state == ACCESS) && (cnt == 4'd0) && !wrQ) rdata <= MemDB;
    end
  end

endmodule

// File: tb/tb_cellram_ctrl.sv
// Bench for cellram_ctrl: RAM model on the bus, per-cycle strobe checks against the access timeline,
// and a scoreboard that pairs every ack with its expected rdata and completion cycle.
module tb_cellram_ctrl;

  localparam int ACC = 4;

  typedef struct {
    logic [15:0] rdata;
    int          ackCnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, cfg;
  logic [22:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic [15:0] rdata;
  logic        ack, busy, memOe, memWr, ramCs, ramAdv, ramLb, ramUb, ramCre, ramClk;
  logic [23:1] memAdr;
  wire  [15:0] memDb;

  logic [15:0] rdata1, rdata15;
  logic        ack1, busy1, oe1, wr1, cs1, adv1, lb1, ub1, cre1, clkOut1;
  logic        ack15, busy15, oe15, wr15, cs15, adv15, lb15, ub15, cre15, clkOut15;
  logic [23:1] adr1, adr15;
  wire  [15:0] db1, db15;

  int   nChecks = 0;
  int   nPass   = 0;
  int   cycCnt  = 0;
  exp_t sbQ[$];
  exp_t sbE;
  logic [15:0] expRdata;
  logic [15:0] shadow [256];

  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  cellram_ctrl #(.ACCESS_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .busy(busy), .MemAdr(memAdr), .MemDB(memDb),
    .MemOE(memOe), .MemWR(memWr), .RamCS(ramCs), .RamAdv(ramAdv), .RamLB(ramLb), .RamUB(ramUb),
    .RamCRE(ramCre), .RamClk(ramClk), .RamWait(1'b0)
  );

  cellram_ctrl #(.ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .MemAdr(adr1), .MemDB(db1),
    .MemOE(oe1), .MemWR(wr1), .RamCS(cs1), .RamAdv(adv1), .RamLB(lb1), .RamUB(ub1),
    .RamCRE(cre1), .RamClk(clkOut1), .RamWait(1'b0)
  );

  cellram_ctrl #(.ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata15), .ack(ack15), .busy(busy15), .MemAdr(adr15), .MemDB(db15),
    .MemOE(oe15), .MemWR(wr15), .RamCS(cs15), .RamAdv(adv15), .RamLB(lb15), .RamUB(ub15),
    .RamCRE(cre15), .RamClk(clkOut15), .RamWait(1'b0)
  );

  // RAM model: undriven bus floats high through the pullup
  function automatic logic [15:0] initWord(input logic [7:0] i);
    if (i == 8'h23) return 16'hBEEF;
    if (i == 8'h10) return 16'hC3C3;
    return {i, ~i};
  endfunction

  logic [15:0]  ram [256];
  logic [255:0] ramWritten = '0;
  logic [22:0]  ramCfg = '0;
  logic [7:0]   ramIdx;
  logic [15:0]  ramOut;

  pullup (memDb);
  assign ramIdx = memAdr[8:1];
  assign ramOut = ramWritten[ramIdx] ? ram[ramIdx] : initWord(ramIdx);
  assign memDb  = (!ramCs && !memOe) ? ramOut : 16'hzzzz;

  always @(posedge clk) begin
    if (!ramCs && !memWr) begin
      if (ramCre) ramCfg <= memAdr;
      else begin
        ram[ramIdx] <= {ramUb ? ramOut[15:8] : memDb[15:8], ramLb ? ramOut[7:0] : memDb[7:0]};
        ramWritten[ramIdx] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sbQ.size() == 0) check("ackSpurious", 32'(ack), 32'd0);
      else begin
        sbE = sbQ.pop_front();
        check("rdata", 32'(rdata), 32'(sbE.rdata));
        check("ackCycle", 32'(cycCnt), 32'(sbE.ackCnt));
      end
    end
  end

  task automatic doAccess(input logic w, input logic c, input logic [22:0] a,
                          input logic [15:0] d, input logic [1:0] b);
    exp_t       e;
    logic       isWr, drv;
    logic [1:0] lanes;
    logic [7:0] v;
    isWr  = w | c;
    drv   = w & ~c;
    lanes = c ? 2'b11 : (w ? ~b : 2'b00);
    if (!isWr) expRdata = shadow[a[7:0]];
    else if (drv) begin
      if (b[0]) shadow[a[7:0]][7:0]  = d[7:0];
      if (b[1]) shadow[a[7:0]][15:8] = d[15:8];
    end
    e.rdata  = expRdata;
    e.ackCnt = cycCnt + ACC + 2;
    sbQ.push_back(e);
    we = w; cfg = c; addr = a; wdata = d; be = b; req = 1'b1;
    for (int k = 1; k <= ACC + 3; k++) begin
      step();
      if (k == 1) begin
        req = 1'b0; we = ~w; addr = ~a; wdata = ~d; be = ~b;
      end
      if (k == 1)             v = {2'b00, 2'b11, lanes, c, 1'b1};
      else if (k <= ACC + 1)  v = {2'b00, isWr, ~isWr, lanes, c, 1'b1};
      else if (k == ACC + 2)  v = 8'b1111_1101;
      else                    v = 8'b1111_1100;
      check("strobes", 32'({ramCs, ramAdv, memOe, memWr, ramUb, ramLb, ramCre, busy}), 32'(v));
      check("memAdr", 32'(memAdr), 32'(a));
      if (drv && k <= ACC + 2) check("dbDrive", 32'(memDb), 32'(d));
      else if (!(k >= 2 && k <= ACC + 1 && !isWr)) check("dbHiZ", 32'(memDb), 32'h0000_FFFF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          base, a1, a15;
    logic [22:0] bbA [3];

    for (int i = 0; i < 256; i++) shadow[i] = initWord(8'(i));
    expRdata = 16'h0000;
    rst = 1'b1; req = 1'b0; we = 1'b0; cfg = 1'b0; addr = '0; wdata = '0; be = 2'b00;
    step(); step();
    check("rstStrobes", 32'({ramCs, ramAdv, memOe, memWr, ramUb, ramLb, ramCre, busy}), 32'h0000_00FC);
    check("rstAdr", 32'(memAdr), 32'd0);
    check("rstRdata", 32'(rdata), 32'd0);
    check("rstAck", 32'(ack), 32'd0);
    check("rstDb", 32'(memDb), 32'h0000_FFFF);
    check("ramClk", 32'(ramClk), 32'd0);
    rst = 1'b0;
    step();

    doAccess(1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11);
    doAccess(1'b1, 1'b0, 23'h000010, 16'h1234, 2'b01);
    doAccess(1'b0, 1'b0, 23'h000010, 16'h0000, 2'b11);
    doAccess(1'b0, 1'b1, 23'h080000, 16'h5A5A, 2'b11);
    check("cfgReg", 32'(ramCfg), 32'h0008_0000);
    doAccess(1'b1, 1'b0, 23'h000044, 16'h0F0E, 2'b11);
    doAccess(1'b1, 1'b0, 23'h000044, 16'h7777, 2'b00);
    doAccess(1'b0, 1'b0, 23'h000044, 16'h0000, 2'b11);
    doAccess(1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b11);

    // req held high across three reads
    bbA  = '{23'h000123, 23'h000044, 23'h7FFFFF};
    base = cycCnt;
    for (int i = 0; i < 3; i++) begin
      e.rdata  = shadow[bbA[i][7:0]];
      e.ackCnt = base + ACC + 2 + 7 * i;
      sbQ.push_back(e);
      expRdata = e.rdata;
    end
    we = 1'b0; cfg = 1'b0; be = 2'b11; addr = bbA[0]; req = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      check("b2bBusy", 32'(busy), (k % 7 == 0) ? 32'd0 : 32'd1);
      if (k == 7)  addr = bbA[1];
      if (k == 14) addr = bbA[2];
      if (k == 15) req = 1'b0;
    end
    check("b2bDrained", 32'(sbQ.size()), 32'd0);

    // reset on the second ACCESS cycle of a write
    we = 1'b1; cfg = 1'b0; addr = 23'h000055; wdata = 16'h6789; be = 2'b11; req = 1'b1;
    step(); req = 1'b0;
    step(); step();
    check("midWrLow", 32'(memWr), 32'd0);
    rst = 1'b1;
    #1;
    check("abortStrobes", 32'({ramCs, ramAdv, memOe, memWr, ramUb, ramLb, ramCre, busy}), 32'h0000_00FC);
    check("abortDb", 32'(memDb), 32'h0000_FFFF);
    check("abortAdr", 32'(memAdr), 32'd0);
    check("abortRdata", 32'(rdata), 32'd0);
    expRdata = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) step();
    doAccess(1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11);

    // ACCESS_CYCLES boundaries, request raised together with reset release
    rst = 1'b1;
    step(); step();
    rst = 1'b0; expRdata = 16'h0000;
    we = 1'b0; cfg = 1'b0; addr = 23'h7FFFFF; be = 2'b11; req = 1'b1;
    e.rdata  = shadow[8'hFF];
    e.ackCnt = cycCnt + ACC + 2;
    sbQ.push_back(e);
    expRdata = e.rdata;
    step(); req = 1'b0;
    base = cycCnt;
    a1 = 0; a15 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ack1 && a1 == 0)   a1  = cycCnt;
      if (ack15 && a15 == 0) a15 = cycCnt;
    end
    check("ack1Cycle", 32'(a1), 32'(base + 2));
    check("ack15Cycle", 32'(a15), 32'(base + 16));
    check("sbDrained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/cellram_ctrl.md
CELLRAM_CTRL -- requirements
Module: cellram_ctrl

Interface
REQ-001 Parameter ACCESS_CYCLES, default 4, SHALL set the OE#/WE# assertion width in clk cycles; legal range 1..15, and 0 SHALL be treated as 1.
REQ-002 One clock and one reset: reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock; every flop on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req  in  1  access request; sampled only in IDLE.
REQ-006 we  in  1  1 = write, 0 = read.
REQ-007 cfg  in  1  1 = configuration-register write (CRE access); forces a write.
REQ-008 addr  in  23  word address; for cfg it carries the register opcode and value.
REQ-009 wdata  in  16  write data.
REQ-010 be  in  2  byte enables, active-high; bit1 = upper byte, bit0 = lower byte.
REQ-011 rdata  out  16  read data, registered.
REQ-012 ack  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high from the cycle after acceptance until IDLE is re-entered.
REQ-014 MemAdr  out  [23:1]  RAM address.
REQ-015 MemDB  inout  16  RAM data bus.
REQ-016 MemOE, MemWR, RamCS, RamAdv, RamLB, RamUB  out  1 each  active-low RAM strobes.
REQ-017 RamCRE  out  1  RAM control-register enable, active-high.
REQ-018 RamClk  out  1  held 0 (asynchronous mode).
REQ-019 RamWait  in  1  ignored.

Function
REQ-020 All RAM-side outputs and MemDB output-enable SHALL come from flops, with no combinational path from inputs.
REQ-021 States SHALL be IDLE, SETUP, ACCESS and HOLD.
REQ-022 IDLE: RamCS, RamAdv, MemOE, MemWR, RamLB and RamUB = 1; RamCRE = 0; MemDB hi-Z; busy = 0.
REQ-023 IDLE with req=1: latch addr, wdata, be, we and cfg, then go to SETUP; req in any other state SHALL be ignored.
REQ-024 SETUP (1 cycle): MemAdr = latched addr; RamCS = 0; RamAdv = 0; RamCRE = latched cfg; MemOE and MemWR stay 1.
REQ-025 SETUP byte lanes: RamUB = ~be[1] and RamLB = ~be[0] for writes; both 0 for reads; both 1 for cfg.
REQ-026 SETUP data bus: MemDB driven with wdata for non-cfg writes from this state through HOLD; otherwise hi-Z.
REQ-027 ACCESS lasts exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter; MemOE = 0 for reads, MemWR = 0 for writes and cfg.
REQ-028 On the last ACCESS cycle of a read, MemDB SHALL be captured into rdata.
REQ-029 HOLD (1 cycle): MemOE, MemWR, RamCS, RamAdv, RamLB and RamUB = 1; RamCRE = 0; MemAdr held; write data still driven; ack = 1.
REQ-030 HOLD SHALL return to IDLE.
REQ-031 Latency: request accepted on edge T gives ack in cycle T+2+ACCESS_CYCLES.
REQ-032 Minimum request spacing SHALL be ACCESS_CYCLES+3 cycles.
REQ-033 rdata SHALL hold its value until the next read capture; writes and cfg accesses SHALL not alter it.
REQ-034 be=00 write: a full cycle SHALL run with RamLB = RamUB = 1, and ack SHALL be generated normally.
REQ-035 cfg=1 SHALL override we; MemDB hi-Z throughout the cycle.
REQ-036 MemAdr SHALL only change in IDLE-to-SETUP transitions and on reset.

Reset
REQ-037 rst=1 SHALL immediately force IDLE, all strobe values per REQ-022, MemAdr = 0, rdata = 0, ack = 0, busy = 0, counter = 0, and MemDB hi-Z, regardless of clk.
REQ-038 After rst falls, req SHALL be accepted on the first rising edge.
REQ-039 Reset during ACCESS SHALL abort the access with no ack, even across the deassertion.

Verification
REQ-040 Read: ACCESS_CYCLES=4, RAM model holds 16'hBEEF at 23'h000123, req at T -> RamCS low T+1..T+5, MemOE low T+2..T+5, ack at T+6, rdata = 16'hBEEF.
REQ-041 Byte write: we=1, addr=23'h000010, wdata=16'h1234, be=2'b01 -> RamLB=0, RamUB=1, MemWR low 4 cycles; read-back returns the old upper byte and 8'h34 in the lower byte.
REQ-042 Config write: cfg=1, addr=23'h080000 -> RamCRE=1 during SETUP/ACCESS, MemWR low, MemDB hi-Z, ack at T+6, rdata unchanged.
REQ-043 Back-to-back: req held high for 3 reads -> accepts every 7 cycles, 3 ack pulses, busy low for exactly one cycle between accesses.
REQ-044 Reset mid-access: rst pulsed on the 2nd ACCESS cycle of a write -> MemWR, RamCS and RamAdv go to 1 immediately, MemDB hi-Z, no ack, and the next req is accepted normally.
REQ-045 Boundaries: addr=23'h7FFFFF read; ACCESS_CYCLES=1 gives ack at T+3; ACCESS_CYCLES=15 gives ack at T+17.
